// File: rtl/bios_read_arbiter_if.sv
// Bus between the pipeline/BIOS memory and the BIOS read arbiter.
// The arbiter takes the slave side; the pipeline and memory model take the master side.
interface bios_read_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              flush;
    logic              bios_en;
    logic [ADDR_W-1:0] bios_addr;
    logic [31:0]       bios_dout;
    logic [31:0]       if_data;
    logic              if_valid;
    logic [31:0]       ld_data;
    logic              ld_valid;
    logic              if_stall;

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr, flush, bios_dout,
        output bios_en, bios_addr, if_data, if_valid, ld_data, ld_valid, if_stall
    );

    modport master (
        output if_req, if_addr, ld_req, ld_addr, flush, bios_dout,
        input  bios_en, bios_addr, if_data, if_valid, ld_data, ld_valid, if_stall
    );
endinterface

// File: rtl/bios_read_arbiter.sv
// Shares the single BIOS read port between fetch and loads. Loads win for at most
// MAX_LD_WINS consecutive cycles against a waiting fetch; responses are routed by owner.
module bios_read_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int MAX_LD_WINS = 2
) (
    input logic                clk,
    input logic                rst,
    bios_read_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

    localparam logic [3:0] MAX_W = 4'(MAX_LD_WINS);

    owner_e      owner_q, owner_d;
    logic [3:0]  win_cnt_q, win_cnt_d;
    logic        flush_q, flush_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        ld_valid_q, ld_valid_d;
    logic        grant_if, grant_ld;
    logic [ADDR_W-1:0] addr_sel;

    always_comb begin
        grant_if = 1'b0;
        grant_ld = 1'b0;
        // Reset blocks every grant so nothing is issued while state is being cleared.
        if (!rst) begin
            if (bus.ld_req && (!bus.if_req || win_cnt_q < MAX_W)) grant_ld = 1'b1;
            else                                                  grant_if = bus.if_req;
        end

        addr_sel = '0;
        if (grant_if)      addr_sel = bus.if_addr;
        else if (grant_ld) addr_sel = bus.ld_addr;

        win_cnt_d = 4'd0;
        if (bus.if_req && grant_ld)
            win_cnt_d = (win_cnt_q == 4'hF) ? win_cnt_q : win_cnt_q + 4'd1;

        // A fetch granted alongside a redirect is recorded as NONE so its data is dropped.
        owner_d = OWN_NONE;
        if (grant_if && !bus.flush) owner_d = OWN_IF;
        else if (grant_ld)          owner_d = OWN_LD;

        flush_d    = bus.flush;
        ld_valid_d = (owner_q == OWN_LD);
        ld_data_d  = (owner_q == OWN_LD) ? bus.bios_dout : ld_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            win_cnt_q  <= 4'd0;
            flush_q    <= 1'b0;
            ld_data_q  <= 32'd0;
            ld_valid_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            win_cnt_q  <= win_cnt_d;
            flush_q    <= flush_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
        end
    end

    assign bus.bios_en   = grant_if | grant_ld;
    assign bus.bios_addr = addr_sel;
    assign bus.if_stall  = bus.if_req & ~grant_if;
    // A redirect arriving on the return cycle kills the wrong-path instruction.
    assign bus.if_valid  = (owner_q == OWN_IF) & ~bus.flush & ~flush_q;
    assign bus.if_data   = (owner_q == OWN_IF) ? bus.bios_dout : 32'd0;
    assign bus.ld_data   = ld_data_q;
    assign bus.ld_valid  = ld_valid_q;
endmodule
